// File: rtl/decoder_seq_pkg.sv
// Shared constants and helpers for the sequenced N-to-2^N decoder.
package decoder_seq_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest one-hot vector supported (SEL_W <= 8); callers cast down to NUM_OUT.
    function automatic logic [255:0] onehot(input logic [7:0] sel, input int unsigned num_out);
        logic [255:0] r;
        r = '0;
        if (32'(sel) < num_out) begin
            r[sel] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_scan_timer.sv
// Dwell counter and line index for SCAN mode; idx/wrap present the values for the coming cycle.
module decoder_scan_timer #(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);

    localparam int unsigned      DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);

    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap_d;

    always_comb begin
        dwell_d = dwell_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        if (clear) begin
            dwell_d = '0;
            idx_d   = '0;
        end else if (run) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q <= '0;
            idx_q   <= '0;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
        end
    end

    assign idx  = idx_d;
    assign wrap = wrap_d;

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with handshake DECODE mode and self-timed SCAN mode.
// Define DECODER_SEQ_RANGE_CHK_EN to add the err out-of-range pulse output.
module decoder_nto2n_seq
    import decoder_seq_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 1 << SEL_W,
    parameter int unsigned DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [NUM_OUT-1:0] out,
    output logic               out_valid,
    output logic               scan_wrap
`ifdef DECODER_SEQ_RANGE_CHK_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic [1:0]         state_q, state_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               wrap_q, wrap_d;
    logic               accept;
    logic               tmr_clear, tmr_run, tmr_wrap;
    logic [IDX_W-1:0]   tmr_idx;

    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DECODE;
        end
    end

    assign in_ready = (state_q == ST_DECODE);
    assign accept   = in_valid & in_ready;

    // Timer is held cleared outside SCAN and on the entry edge, so every scan starts at line 0.
    assign tmr_run   = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    assign tmr_clear = !tmr_run;

    decoder_scan_timer #(
        .DWELL   (DWELL),
        .NUM_OUT (NUM_OUT),
        .IDX_W   (IDX_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .run   (tmr_run),
        .idx   (tmr_idx),
        .wrap  (tmr_wrap)
    );

    always_comb begin
        out_d  = '0;
        wrap_d = 1'b0;
        case (state_d)
            ST_DECODE: begin
                if (state_q != ST_DECODE) begin
                    out_d = '0;
                end else if (accept) begin
                    out_d = NUM_OUT'(onehot(8'(in_sel), NUM_OUT));
                end else begin
                    out_d = out_q;
                end
            end
            ST_SCAN: begin
                out_d  = NUM_OUT'(onehot(8'(tmr_idx), NUM_OUT));
                wrap_d = tmr_wrap;
            end
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef DECODER_SEQ_RANGE_CHK_EN
    logic err_q, err_d;

    assign err_d = accept && (state_d == ST_DECODE) && (32'(in_sel) >= NUM_OUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign out       = out_q;
    assign out_valid = |out_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench: a 4-line/DWELL=2 instance and a 3-line/DWELL=1 instance sharing clock and reset.
module tb_decoder_nto2n_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en4, mode4, iv4, ir4, ov4, wr4;
    logic [1:0] sel4;
    logic [3:0] out4;
    logic       en3, mode3, iv3, ir3, ov3, wr3;
    logic [1:0] sel3;
    logic [2:0] out3;
`ifdef DECODER_SEQ_RANGE_CHK_EN
    logic       err4, err3;
`endif

    int n_total = 0;
    int n_bad   = 0;

    decoder_nto2n_seq #(.SEL_W(2), .NUM_OUT(4), .DWELL(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4),
        .in_valid(iv4), .in_ready(ir4), .in_sel(sel4),
        .out(out4), .out_valid(ov4), .scan_wrap(wr4)
`ifdef DECODER_SEQ_RANGE_CHK_EN
        , .err(err4)
`endif
    );

    decoder_nto2n_seq #(.SEL_W(2), .NUM_OUT(3), .DWELL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3),
        .in_valid(iv3), .in_ready(ir3), .in_sel(sel3),
        .out(out3), .out_valid(ov3), .scan_wrap(wr3)
`ifdef DECODER_SEQ_RANGE_CHK_EN
        , .err(err3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] scan4_out  [13] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8,
                                    4'h1, 4'h1, 4'h2, 4'h2, 4'h4};
    logic [2:0] scan3_out  [5]  = '{3'h1, 3'h2, 3'h4, 3'h1, 3'h2};
    logic       scan3_wrap [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        en4 = 1'b1; mode4 = 1'b1; iv4 = 1'b0; sel4 = 2'd0;
        en3 = 1'b0; mode3 = 1'b0; iv3 = 1'b0; sel3 = 2'd0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_out",   32'(out4), 0);
            check("rst_valid", 32'(ov4),  0);
            check("rst_ready", 32'(ir4),  0);
            check("rst_wrap",  32'(wr4),  0);
        end

        mode4 = 1'b0;
        rst_n = 1'b1;
        step();
        check("dec_entry_ready", 32'(ir4),  1);
        check("dec_entry_out",   32'(out4), 0);
        for (int i = 0; i < 4; i++) begin
            iv4  = 1'b1;
            sel4 = 2'(i);
            step();
            check("dec_out",   32'(out4), 32'(1) << i);
            check("dec_valid", 32'(ov4),  1);
        end
        iv4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("dec_hold", 32'(out4), 8);
        end
`ifdef DECODER_SEQ_RANGE_CHK_EN
        check("dec_err_quiet", 32'(err4), 0);
`endif

        mode4 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            check("scan_out",   32'(out4), 32'(scan4_out[i]));
            check("scan_wrap",  32'(wr4),  (i == 8) ? 1 : 0);
            check("scan_ready", 32'(ir4),  0);
        end

        en4 = 1'b0;
        step();
        check("drop_out",   32'(out4), 0);
        check("drop_valid", 32'(ov4),  0);
        check("drop_ready", 32'(ir4),  0);
        step();
        check("idle_out", 32'(out4), 0);

        en4 = 1'b1;
        step();
        check("rescan_l0a", 32'(out4), 1);
        step();
        check("rescan_l0b", 32'(out4), 1);
        step();
        check("rescan_l1", 32'(out4), 2);

        mode4 = 1'b0;
        iv4   = 1'b1;
        sel4  = 2'd2;
        check("sw_ready_before", 32'(ir4), 0);
        step();
        check("sw_ready_after", 32'(ir4),  1);
        check("sw_out_clear",   32'(out4), 0);
        step();
        check("sw_accept_out", 32'(out4), 4);
        iv4 = 1'b0;
        step();
        check("sw_hold", 32'(out4), 4);

        en3 = 1'b1;
        mode3 = 1'b0;
        step();
        check("n3_ready", 32'(ir3),  1);
        check("n3_entry", 32'(out3), 0);
        iv3 = 1'b1;
        sel3 = 2'd1;
        step();
        check("n3_sel1", 32'(out3), 2);
        sel3 = 2'd3;
        step();
        check("n3_oor_out",   32'(out3), 0);
        check("n3_oor_valid", 32'(ov3),  0);
`ifdef DECODER_SEQ_RANGE_CHK_EN
        check("n3_oor_err", 32'(err3), 1);
`endif
        sel3 = 2'd2;
        step();
        check("n3_sel2", 32'(out3), 4);
`ifdef DECODER_SEQ_RANGE_CHK_EN
        check("n3_err_pulse", 32'(err3), 0);
`endif
        iv3 = 1'b0;
        step();
        check("n3_hold", 32'(out3), 4);

        mode3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("n3_scan_out",  32'(out3), 32'(scan3_out[i]));
            check("n3_scan_wrap", 32'(wr3),  32'(scan3_wrap[i]));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
